ssd_scan_ctl_n: RTL and testbench

Parametrised, time-multiplexed seven-segment scan controller for N common-anode digits. It owns its refresh prescaler and digit counter, and produces the active-low digit-select bus `ssd_ctl` plus the BCD/hex nibble `ssd_in` for the downstream segment decoder. It adds per-digit enable masking, a dark guard interval against ghosting, a run/hold enable and a frame-complete strobe.

---
 rtl/ssd_scan_ctl_n.sv | 103 ++++++++++
 tb/tb_ssd_scan_ctl_n.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctl_n.sv
// Time-multiplexed seven-segment scan controller for DIGITS common-anode digits.
// Optional leading-zero blanking is compiled in with the SSD_SCAN_LZB_EN macro.
module ssd_scan_ctl_n #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 100000,
    parameter int DEAD     = 1,
    localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int CW      = $clog2(PRESCALE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     digit_mask,
    output logic [3:0]            ssd_in,
    output logic [DIGITS-1:0]     ssd_ctl,
    output logic [IW-1:0]         digit_idx,
    output logic                  frame_tick
);

    logic [CW-1:0]     cnt, cnt_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [3:0]        nib_q;
    logic              lit_q, lit_nxt;
    logic              blank_q, blank_nxt, blank_now;
    logic              cnt_last, idx_last, latch, sel_on;
    logic [DIGITS-1:0] ctl_nxt;
    logic [3:0]        nib_arr [DIGITS];

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            nib_arr[i] = digits[4*i +: 4];
        end
    end

`ifdef SSD_SCAN_LZB_EN
    // lz[i]: nibble i and every nibble above it are zero
    logic [DIGITS:0] lz;

    always_comb begin
        lz         = '0;
        lz[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz[i] = lz[i+1] && (nib_arr[i] == 4'h0);
        end
        blank_now = (idx != '0) && lz[idx];
    end
`else
    assign blank_now = 1'b0;
`endif

    always_comb begin
        cnt_last = (cnt == CW'(PRESCALE - 1));
        idx_last = (idx == IW'(DIGITS - 1));
        cnt_nxt  = cnt;
        idx_nxt  = idx;
        if (en) begin
            if (cnt_last) begin
                cnt_nxt = '0;
                idx_nxt = idx_last ? '0 : idx + IW'(1);
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end

        // slot attributes are captured on the edge that leaves cnt = 0
        latch     = en && (cnt == '0);
        lit_nxt   = latch ? digit_mask[idx] : lit_q;
        blank_nxt = latch ? blank_now : blank_q;

        // select is computed from next-state cnt/idx so the flop lines up with cnt
        sel_on  = en && (cnt_nxt >= CW'(DEAD)) && lit_nxt && !blank_nxt;
        ctl_nxt = '1;
        if (sel_on) begin
            ctl_nxt[idx_nxt] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            nib_q   <= '0;
            lit_q   <= 1'b0;
            blank_q <= 1'b0;
            ssd_ctl <= '1;
        end else begin
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            lit_q   <= lit_nxt;
            blank_q <= blank_nxt;
            ssd_ctl <= ctl_nxt;
            if (latch) begin
                nib_q <= nib_arr[idx];
            end
        end
    end

    assign ssd_in     = nib_q;
    assign digit_idx  = idx;
    assign frame_tick = !rst && en && cnt_last && idx_last;

endmodule

// File: tb/tb_ssd_scan_ctl_n.sv
// Randomised self-checking bench for ssd_scan_ctl_n (DIGITS=4, PRESCALE=8, DEAD=2)
// against a slot-level behavioural model; honours SSD_SCAN_LZB_EN like the design.
module tb_ssd_scan_ctl_n;

    localparam int D = 4;
    localparam int P = 8;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  digit_mask;
    logic [3:0]  ssd_in;
    logic [3:0]  ssd_ctl;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // model state: position in the frame plus what the current slot latched
    int       m_cnt, m_idx;
    logic [3:0] m_nib, m_ctl;
    bit       m_lit, m_blank;

    ssd_scan_ctl_n #(.DIGITS(D), .PRESCALE(P), .DEAD(G)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digits     (digits),
        .digit_mask (digit_mask),
        .ssd_in     (ssd_in),
        .ssd_ctl    (ssd_ctl),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit lzb_blank(input int i, input logic [15:0] d);
`ifdef SSD_SCAN_LZB_EN
        return (i > 0) && ((d >> (4 * i)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    // one clock cycle: check state-derived outputs, apply inputs, check tick, advance model
    task automatic cycle(input logic r, input logic e, input logic [15:0] d, input logic [3:0] m);
        check("ssd_ctl", ssd_ctl, m_ctl);
        check("ssd_in", ssd_in, m_nib);
        check("digit_idx", digit_idx, m_idx);
        rst = r; en = e; digits = d; digit_mask = m;
        #1;
        check("frame_tick", frame_tick, !r && e && m_cnt == P - 1 && m_idx == D - 1);
        if (r) begin
            m_cnt = 0; m_idx = 0; m_nib = 0; m_lit = 0; m_blank = 0; m_ctl = 4'hF;
        end else begin
            if (e && m_cnt == 0) begin
                m_nib   = 4'((d >> (4 * m_idx)) & 16'hF);
                m_lit   = m[m_idx];
                m_blank = lzb_blank(m_idx, d);
            end
            if (e) begin
                if (m_cnt == P - 1) begin
                    m_cnt = 0;
                    m_idx = (m_idx + 1) % D;
                end else begin
                    m_cnt++;
                end
            end
            m_ctl = (e && m_cnt >= G && m_lit && !m_blank) ? ~(4'b0001 << m_idx) : 4'hF;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 16'h0, 4'h0);
        cycle(1'b1, 1'b0, 16'h0, 4'h0);
    endtask

    initial begin
        logic [15:0] rd;
        logic [3:0]  rm;
        rst = 1'b1; en = 1'b0; digits = 16'h0; digit_mask = 4'h0;
        repeat (2) @(negedge clk);
        m_cnt = 0; m_idx = 0; m_nib = 0; m_lit = 0; m_blank = 0; m_ctl = 4'hF;
        do_reset();
        check("rst_ctl", ssd_ctl, 4'b1111);
        check("rst_in", ssd_in, 4'h0);
        check("rst_idx", digit_idx, 2'd0);
        check("rst_tick", frame_tick, 1'b0);

        // basic scan, with spot checks of the documented select pattern
        for (int k = 0; k < 32; k++) begin
            if (k == 1)  check("s0_dead", ssd_ctl, 4'b1111);
            if (k == 2)  check("s0_lit", ssd_ctl, 4'b1110);
            if (k == 7)  check("s0_nib", ssd_in, 4'h4);
            if (k == 12) check("s1_lit", ssd_ctl, 4'b1101);
            if (k == 30) check("s3_lit", ssd_ctl, 4'b0111);
            if (k == 30) check("s3_nib", ssd_in, 4'h1);
            cycle(1'b0, 1'b1, 16'h1234, 4'hF);
        end

        // mask digit 2
        for (int k = 0; k < 32; k++) begin
            if (k == 20) check("mask_s2", ssd_ctl, 4'b1111);
            cycle(1'b0, 1'b1, 16'h1234, 4'b1011);
        end

        // hold at slot 1, cnt 4
        for (int k = 0; k < 12; k++) cycle(1'b0, 1'b1, 16'h1234, 4'hF);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 16'h1234, 4'hF);
        check("hold_ctl", ssd_ctl, 4'b1111);
        check("hold_idx", digit_idx, 2'd1);
        for (int k = 0; k < 12; k++) cycle(1'b0, 1'b1, 16'h1234, 4'hF);

        // mid-slot data change after a mid-frame reset
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 16'h1234, 4'hF);
        for (int k = 3; k < 16; k++) begin
            if (k == 6)  check("mid_s0", ssd_in, 4'h4);
            if (k == 12) check("mid_s1", ssd_in, 4'hC);
            cycle(1'b0, 1'b1, 16'hABCD, 4'hF);
        end

        // leading-zero patterns
        do_reset();
        for (int k = 0; k < 32; k++) cycle(1'b0, 1'b1, 16'h0050, 4'hF);
        for (int k = 0; k < 32; k++) cycle(1'b0, 1'b1, 16'h0000, 4'hF);

        // randomised traffic
        rd = 16'h1234; rm = 4'hF;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                for (int n = 0; n < 4; n++)
                    rd[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                rm = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            end
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0, rd, rm);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
